// File: rtl/abs_sum_stream.sv
// Streaming absolute-sum accumulator: sums every signed channel of every beat in a frame,
// then holds |total| (saturated) with overflow/truncation flags until the consumer takes it.
module abs_sum_stream #(
    parameter int WIDTH     = 4,
    parameter int NCH       = 4,
    parameter int OUT_W     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_sum,
    output logic                   out_ovf,
    output logic                   out_trunc
);

    localparam int SUM_W     = WIDTH + $clog2(NCH);
    localparam int ACC_W_RAW = SUM_W + $clog2(MAX_BEATS);
    localparam int ACC_W     = (ACC_W_RAW < SUM_W + 1) ? SUM_W + 1 : ACC_W_RAW;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);
    // One spare bit above both widths so the saturation compare never truncates either side.
    localparam int EXT_W     = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_trunc_q, out_trunc_d;

    logic [ACC_W-1:0]   beat_sum_s;
    logic [ACC_W-1:0]   acc_sum_s;
    logic [ACC_W-1:0]   mag_s;
    logic [EXT_W-1:0]   mag_ext_s;
    logic [EXT_W-1:0]   sat_lim_s;
    logic               sat_s;
    logic               at_max_s;
    logic               accept_s;

    // Sign-extend every channel to the accumulator width and add them up.
    function automatic logic [ACC_W-1:0] beat_sum_f(input logic [NCH*WIDTH-1:0] data);
        logic [ACC_W-1:0] total;
        logic [WIDTH-1:0] chan;
        total = {ACC_W{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            chan  = data[k*WIDTH +: WIDTH];
            total = total + {{(ACC_W-WIDTH){chan[WIDTH-1]}}, chan};
        end
        return total;
    endfunction

    // Unsigned magnitude; the most negative value maps to 2^(ACC_W-1) without wrapping.
    function automatic logic [ACC_W-1:0] abs_f(input logic [ACC_W-1:0] val);
        logic [ACC_W-1:0] res;
        if (val[ACC_W-1]) begin
            res = ~val + ACC_W'(1);
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Datapath: closing value, its magnitude and the saturation decision.
    always_comb begin
        beat_sum_s = beat_sum_f(in_data);
        acc_sum_s  = acc_q + beat_sum_s;
        mag_s      = abs_f(acc_sum_s);
        mag_ext_s  = EXT_W'(mag_s);
        sat_lim_s  = {{(EXT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
        sat_s      = (mag_ext_s > sat_lim_s);
        at_max_s   = (cnt_q == CNT_W'(MAX_BEATS - 1));
        accept_s   = in_valid && (state_q == ST_ACCUM);
    end

    // Next-state logic for the accumulate/hold FSM and its registered outputs.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_trunc_d = out_trunc_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept_s) begin
                    acc_d = acc_sum_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (in_last || at_max_s) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_ovf_d   = sat_s;
                        out_trunc_d = !in_last;
                        if (sat_s) begin
                            out_sum_d = {OUT_W{1'b1}};
                        end else begin
                            out_sum_d = mag_s[OUT_W-1:0];
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_ACCUM;
                    acc_d       = {ACC_W{1'b0}};
                    cnt_d       = {CNT_W{1'b0}};
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_ACCUM;
                acc_d       = {ACC_W{1'b0}};
                cnt_d       = {CNT_W{1'b0}};
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_sum_q   <= {OUT_W{1'b0}};
            out_ovf_q   <= 1'b0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign out_trunc = out_trunc_q;

endmodule

// File: doc/abs_sum_stream.md
# abs_sum_stream

Streaming, parametrised absolute-sum accumulator for the arithmetic datapath. Each accepted beat carries NCH signed WIDTH-bit channel samples. The block sums all channels of all beats in a frame. At frame end it presents the absolute value of the total, saturated to OUT_W bits, together with overflow and truncation flags, on a valid/ready output port.

## Interface
- WIDTH, 4: bits per signed channel sample (two's complement), ≥2
- NCH, 4: channels per beat, ≥1
- OUT_W, 8: unsigned result width, ≥1
- MAX_BEATS, 16: maximum beats per frame; reaching it forces frame close, ≥1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat present
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  NCH*WIDTH  packed samples; channel k = in_data[k*WIDTH +: WIDTH], signed
- in_last  in  1  final beat of frame; qualified by in_valid
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_sum  out  OUT_W  |frame total|, saturated to 2^OUT_W-1
- out_ovf  out  1  |total| exceeded 2^OUT_W-1
- out_trunc  out  1  frame closed by MAX_BEATS, not by in_last

## Operation
- Widths: SUM_W = WIDTH+clog2(NCH); ACC_W = SUM_W+clog2(MAX_BEATS), minimum SUM_W+1. All channel samples are sign-extended to ACC_W before the add. Accumulator never wraps.
- Beat sum = signed sum of the NCH channels (combinational). Handshake: accept = in_valid && in_ready.
- FSM states:
  - ACCUM: in_ready=1, out_valid=0. On accept: acc <= acc + beat_sum; beat_cnt <= beat_cnt+1.
    - Frame closes on accept when in_last=1, or when beat_cnt == MAX_BEATS-1. Go to HOLD.
    - Load result from acc + beat_sum, the value that includes the closing beat.
  - HOLD: in_ready=0, out_valid=1; out_* stable. On out_ready=1: clear acc and beat_cnt, go to ACCUM.
- Result:
  - mag = |total|, taken in ACC_W-bit unsigned arithmetic. The most negative total is handled without wrap.
  - out_sum = (mag > 2^OUT_W-1) ? all-ones : mag[OUT_W-1:0]
  - out_ovf = (mag > 2^OUT_W-1)
  - out_trunc = 1 only if the close was forced by MAX_BEATS with in_last=0. in_last on beat MAX_BEATS gives trunc=0.
- A zero total gives out_sum=0 and out_ovf=0.
- in_last or in_valid while in HOLD are ignored; no beat is accepted.
- Reset (async, any state, including mid-frame): state=ACCUM, acc=0, beat_cnt=0, out_valid=0, out_sum=0, out_ovf=0, out_trunc=0. in_ready goes to 1 once reset is released. A partial frame is discarded.

## Timing
- in_ready is a registered-state decode: 1 in ACCUM, 0 in HOLD. No combinational path from out_ready to in_ready.
- Latency: closing beat accepted at edge N; out_valid=1 and result visible after edge N.
- Output handshake at edge M with out_valid && out_ready: out_valid=0 and in_ready=1 after M. The next beat is accepted at M+1 at the earliest, giving 1 bubble cycle per frame.
- Throughput: a frame of B beats occupies B + 1 + (out_ready wait) cycles.
- out_sum, out_ovf and out_trunc change only on frame close or reset. They are stable throughout HOLD; after the handshake they hold their last value (don't-care while out_valid=0).
- Single-beat frame (in_last on the first beat) is legal and follows the same timing.

## Test plan
- Defaults (OUT_W=8), one beat {3,-2,4,-1}, in_last=1, out_ready=1 -> out_valid 1 cycle after accept; out_sum=4, ovf=0, trunc=0; in_ready back to 1 the following cycle.
- One beat {-8,-7,-6,-4}, last -> out_sum=25, ovf=0. Same stimulus with OUT_W=4 -> out_sum=15, ovf=1.
- Two-beat frame {7,5,2,1} then {-8,-8,-8,-8} last (total -17), OUT_W=8 -> out_sum=17. Hold out_ready=0 for 3 cycles with in_valid=1 asserted -> outputs stable, in_ready=0, no beat consumed, acc unchanged.
- MAX_BEATS=4: four beats {1,1,1,1} with in_last=0 -> out_sum=16, trunc=1, closes after the 4th accept. Repeat with in_last on beat 4 -> trunc=0.
- Extreme: MAX_BEATS=16, sixteen beats {-8,-8,-8,-8} (total -512), OUT_W=10 -> out_sum=512, ovf=0. With OUT_W=9 -> 511, ovf=1.
- Assert rst_n low after 2 beats of a frame -> all outputs 0 immediately. Then a frame {1,2,3,4} last -> out_sum=10; no residue from the discarded beats.
